zx_video_gen: RTL and testbench

- Spectrum ULA-style raster generator; sits directly upstream of the video mixer.
- Produces per-pixel 6-bit R/G/B, positive HSync/VSync and line_start (hblank), all paced by ce_pix.
- Fetches bitmap/attribute bytes from video RAM and applies flash, bright and border colour.
- Generates the CPU frame interrupt.

---
 rtl/zx_video_pkg.sv | 25 ++
 rtl/zx_video_gen_palette.sv | 27 ++
 rtl/zx_video_gen.sv | 158 +++++++++++++++
 tb/tb_zx_video_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/zx_video_pkg.sv
// Timing constants and colour type shared by the ZX raster generator.
package zx_video_pkg;

  localparam logic [8:0] LEN48    = 9'd448;
  localparam logic [8:0] LINES48  = 9'd312;
  localparam logic [8:0] LEN128   = 9'd456;
  localparam logic [8:0] LINES128 = 9'd311;

  localparam logic [8:0] HBLANK_START = 9'd320;
  localparam logic [8:0] HBLANK_END   = 9'd415;
  localparam logic [8:0] HSYNC_START  = 9'd344;
  localparam logic [8:0] HSYNC_END    = 9'd375;
  localparam logic [8:0] VBLANK_START = 9'd248;
  localparam logic [8:0] VBLANK_END   = 9'd255;
  localparam logic [8:0] VSYNC_START  = 9'd248;
  localparam logic [8:0] VSYNC_END    = 9'd251;
  localparam logic [8:0] INT_LINE     = 9'd248;
  localparam logic [8:0] INT_LEN      = 9'd64;

  localparam logic [8:0] PAPER_W = 9'd256;
  localparam logic [8:0] PAPER_H = 9'd192;

  typedef logic [2:0] zx_colour_t;

endpackage

// File: rtl/zx_video_gen_palette.sv
// ULAplus 64-entry palette: GGGRRRBB entries written on clk_sys, read
// combinationally and widened to 6 bits per component.
module zx_palette (
  input  logic       clk_sys,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [7:0] wdata,
  input  logic [5:0] raddr,
  output logic [5:0] r,
  output logic [5:0] g,
  output logic [5:0] b
);

  // No reset: palette contents survive a video reset.
  logic [7:0] mem [64];
  logic [7:0] entry;

  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
  end

  assign entry = mem[raddr];
  assign g = {entry[7:5], entry[7:5]};
  assign r = {entry[4:2], entry[4:2]};
  assign b = {entry[1:0], entry[1:0], entry[1:0]};

endmodule

// File: rtl/zx_video_gen.sv
// Spectrum ULA-style raster generator: counters, VRAM fetch, pixel shifter,
// flash/bright/border colour, syncs and frame interrupt. ULAPLUS_EN adds the palette.
module zx_video_gen
  import zx_video_pkg::*;
#(
  parameter logic [5:0] NORM_LVL   = 6'd40,
  parameter logic [5:0] BRIGHT_LVL = 6'd63
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        mode_128,
  input  logic [2:0]  border,
  output logic [13:0] vram_addr,
  input  logic [7:0]  vram_data,
  input  logic        pal_we,
  input  logic [5:0]  pal_addr,
  input  logic [7:0]  pal_data,
  input  logic        pal_enable,
  output logic [5:0]  R,
  output logic [5:0]  G,
  output logic [5:0]  B,
  output logic        HSync,
  output logic        VSync,
  output logic        line_start,
  output logic        int_n
);

  logic [8:0] hc, vc, hc_last, vc_last;
  logic       mode_r;
  logic [4:0] flash_cnt;
  logic [7:0] bitmap_lat, attr_lat, shift_r, attr_r;
  zx_colour_t border_r;

  logic       hc_wrap, vc_wrap, fetch, paper, hblank, vblank, pix_on;
  zx_colour_t col;
  logic       bright;
  logic [5:0] lvl, r_std, g_std, b_std, r_nxt, g_nxt, b_nxt;

  // Frame geometry only changes at the frame wrap, via mode_r.
  assign hc_last = mode_r ? LEN128 - 9'd1 : LEN48 - 9'd1;
  assign vc_last = mode_r ? LINES128 - 9'd1 : LINES48 - 9'd1;
  assign hc_wrap = (hc == hc_last);
  assign vc_wrap = (vc == vc_last);

  assign fetch  = (vc < PAPER_H) && (hc < PAPER_W);
  assign paper  = (vc < PAPER_H) && (hc >= 9'd8) && (hc < PAPER_W + 9'd8);
  assign hblank = (hc >= HBLANK_START) && (hc <= HBLANK_END);
  assign vblank = (vc >= VBLANK_START) && (vc <= VBLANK_END);
  assign pix_on = shift_r[7] ^ (flash_cnt[4] & attr_r[7]);

  always_comb begin
    col    = border_r;
    bright = 1'b0;
    if (paper) begin
      col    = pix_on ? attr_r[2:0] : attr_r[5:3];
      bright = attr_r[6];
    end
    lvl   = bright ? BRIGHT_LVL : NORM_LVL;
    r_std = col[1] ? lvl : 6'd0;
    g_std = col[2] ? lvl : 6'd0;
    b_std = col[0] ? lvl : 6'd0;
  end

`ifdef ULAPLUS_EN
  logic [5:0] pal_idx, pal_r, pal_g, pal_b;

  // Flash is ignored in palette mode; paper entries sit in the upper 8 of each 16.
  assign pal_idx = paper ? {attr_r[7:6], ~shift_r[7], shift_r[7] ? attr_r[2:0] : attr_r[5:3]}
                         : {3'b001, border_r};

  zx_palette u_palette (
    .clk_sys (clk_sys),
    .we      (pal_we),
    .waddr   (pal_addr),
    .wdata   (pal_data),
    .raddr   (pal_idx),
    .r       (pal_r),
    .g       (pal_g),
    .b       (pal_b)
  );

  assign r_nxt = pal_enable ? pal_r : r_std;
  assign g_nxt = pal_enable ? pal_g : g_std;
  assign b_nxt = pal_enable ? pal_b : b_std;
`else
  logic unused_pal;
  assign unused_pal = ^{pal_we, pal_addr, pal_data, pal_enable};
  assign r_nxt = r_std;
  assign g_nxt = g_std;
  assign b_nxt = b_std;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hc         <= '0;
      vc         <= '0;
      mode_r     <= mode_128;
      flash_cnt  <= '0;
      bitmap_lat <= '0;
      attr_lat   <= '0;
      shift_r    <= '0;
      attr_r     <= '0;
      border_r   <= '0;
      vram_addr  <= '0;
      R          <= '0;
      G          <= '0;
      B          <= '0;
      HSync      <= 1'b0;
      VSync      <= 1'b0;
      line_start <= 1'b0;
      int_n      <= 1'b1;
    end else if (ce_pix) begin
      if (hc_wrap) begin
        hc <= '0;
        if (vc_wrap) begin
          vc        <= '0;
          mode_r    <= mode_128;
          flash_cnt <= flash_cnt + 5'd1;
        end else begin
          vc <= vc + 9'd1;
        end
      end else begin
        hc <= hc + 9'd1;
      end

      if (fetch) begin
        case (hc[2:0])
          3'd0: vram_addr <= {1'b0, vc[7:6], vc[2:0], vc[5:3], hc[7:3]};
          3'd2: begin
            bitmap_lat <= vram_data;
            vram_addr  <= {4'b0110, vc[7:3], hc[7:3]};
          end
          3'd4: attr_lat <= vram_data;
          default: ;
        endcase
      end

      // The last pixel of a group still leaves from shift_r[7] as the next group loads.
      if (hc[2:0] == 3'd7) begin
        shift_r  <= bitmap_lat;
        attr_r   <= attr_lat;
        border_r <= border;
      end else begin
        shift_r <= {shift_r[6:0], 1'b0};
      end

      R          <= (hblank || vblank) ? 6'd0 : r_nxt;
      G          <= (hblank || vblank) ? 6'd0 : g_nxt;
      B          <= (hblank || vblank) ? 6'd0 : b_nxt;
      line_start <= hblank;
      HSync      <= (hc >= HSYNC_START) && (hc <= HSYNC_END);
      VSync      <= (vc >= VSYNC_START) && (vc <= VSYNC_END);
      int_n      <= !((vc == INT_LINE) && (hc < INT_LEN));
    end
  end

endmodule

// File: tb/tb_zx_video_gen.sv
// Directed bench for zx_video_gen: pixel/sync vector table plus frame-length,
// flash, mid-frame reset and palette sequences.
module tb_zx_video_gen;

  logic        clk_sys = 1'b0;
  logic        reset, ce_pix, mode_128;
  logic [2:0]  border;
  logic [13:0] vram_addr;
  logic [7:0]  vram_data;
  logic        pal_we, pal_enable;
  logic [5:0]  pal_addr;
  logic [7:0]  pal_data;
  logic [5:0]  R, G, B;
  logic        HSync, VSync, line_start, int_n;

  logic [7:0]  bitmap_val, attr_val;
  int          errors = 0;
  int          checks = 0;
  int          bhc, bvc, bframe;
  logic        bmode;

  always #5 clk_sys = ~clk_sys;

  zx_video_gen dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .mode_128   (mode_128),
    .border     (border),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .pal_enable (pal_enable),
    .R          (R),
    .G          (G),
    .B          (B),
    .HSync      (HSync),
    .VSync      (VSync),
    .line_start (line_start),
    .int_n      (int_n)
  );

  // Video RAM: bitmap area below 0x1800, attributes above; one clk_sys read latency.
  always @(posedge clk_sys)
    vram_data <= (vram_addr < 14'h1800) ? bitmap_val : attr_val;

  typedef struct {
    int         vc;
    int         hc;
    logic [5:0] r, g, b;
    logic [3:0] flags;    // {HSync, VSync, line_start, int_n}
    logic       chk_addr;
    logic [13:0] addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int v, input int h, input logic [5:0] r, input logic [5:0] g,
                              input logic [5:0] b, input logic [3:0] f,
                              input logic ca = 1'b0, input logic [13:0] a = 14'h0);
    vec_t t;
    t.vc = v; t.hc = h; t.r = r; t.g = g; t.b = b; t.flags = f; t.chk_addr = ca; t.addr = a;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One ce_pix pulse; the bench position then names the pixel now on the outputs.
  task automatic tick();
    @(negedge clk_sys); ce_pix = 1'b1;
    @(negedge clk_sys); ce_pix = 1'b0;
    if (bhc == (bmode ? 455 : 447)) begin
      bhc = 0;
      if (bvc == (bmode ? 310 : 311)) begin
        bvc = 0; bmode = mode_128; bframe++;
      end else bvc++;
    end else bhc++;
  endtask

  task automatic goto_pix(input int f, input int v, input int h);
    int guard = 0;
    while (!(bframe == f && bvc == v && bhc == h) && guard < 3000000) begin
      tick();
      guard++;
    end
    if (guard >= 3000000) begin
      checks++; errors++;
      $display("FAIL goto: frame %0d pos %0d,%0d never reached", f, v, h);
    end
    tick();
  endtask

  task automatic frame_len(output int n, output int low);
    logic prev = 1'b1;
    n = 0; low = 0;
    while (n < 200000) begin
      tick();
      n++;
      if (!int_n) low++;
      if (VSync && !prev) break;
      prev = VSync;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys); reset = 1'b1; ce_pix = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("reset_rgb", {14'h0, R, G, B}, 32'h0);
    check("reset_sync", {28'h0, HSync, VSync, line_start, int_n}, 32'h1);
    check("reset_addr", {18'h0, vram_addr}, 32'h0);
    reset = 1'b0;
    bhc = 0; bvc = 0; bframe = 0; bmode = mode_128;
  endtask

  initial begin
    int n, low;
    reset = 1'b1; ce_pix = 1'b0; mode_128 = 1'b0; border = 3'b010;
    pal_we = 1'b0; pal_addr = '0; pal_data = '0; pal_enable = 1'b0;
    bitmap_val = 8'hA5; attr_val = 8'h47;

    vecs.push_back(mk(0,   8,  63, 63, 63, 4'b0001));
    vecs.push_back(mk(0,   9,   0,  0,  0, 4'b0001));
    vecs.push_back(mk(0,  10,  63, 63, 63, 4'b0001));
    vecs.push_back(mk(0,  11,   0,  0,  0, 4'b0001));
    vecs.push_back(mk(0,  12,   0,  0,  0, 4'b0001));
    vecs.push_back(mk(0,  13,  63, 63, 63, 4'b0001));
    vecs.push_back(mk(0,  14,   0,  0,  0, 4'b0001));
    vecs.push_back(mk(0,  15,  63, 63, 63, 4'b0001));
    vecs.push_back(mk(0, 264,  40,  0,  0, 4'b0001));
    vecs.push_back(mk(0, 319,  40,  0,  0, 4'b0001));
    vecs.push_back(mk(0, 320,   0,  0,  0, 4'b0011));
    vecs.push_back(mk(0, 343,   0,  0,  0, 4'b0011));
    vecs.push_back(mk(0, 344,   0,  0,  0, 4'b1011));
    vecs.push_back(mk(0, 375,   0,  0,  0, 4'b1011));
    vecs.push_back(mk(0, 376,   0,  0,  0, 4'b0011));
    vecs.push_back(mk(0, 415,   0,  0,  0, 4'b0011));
    vecs.push_back(mk(0, 416,  40,  0,  0, 4'b0001));
    vecs.push_back(mk(1,   8,  63, 63, 63, 4'b0001));
    vecs.push_back(mk(65,  16, 63, 63, 63, 4'b0001, 1'b1, 14'h0902));
    vecs.push_back(mk(65,  17,  0,  0,  0, 4'b0001, 1'b1, 14'h0902));
    vecs.push_back(mk(65,  18, 63, 63, 63, 4'b0001, 1'b1, 14'h1902));
    vecs.push_back(mk(191, 15, 63, 63, 63, 4'b0001));
    vecs.push_back(mk(191, 264, 40, 0,  0, 4'b0001));
    vecs.push_back(mk(192,  8, 40,  0,  0, 4'b0001));
    vecs.push_back(mk(247, 63, 40,  0,  0, 4'b0001));
    vecs.push_back(mk(248,  0,  0,  0,  0, 4'b0100));
    vecs.push_back(mk(248, 63,  0,  0,  0, 4'b0100));
    vecs.push_back(mk(248, 64,  0,  0,  0, 4'b0101));
    vecs.push_back(mk(251, 100, 0,  0,  0, 4'b0101));
    vecs.push_back(mk(252, 100, 0,  0,  0, 4'b0001));
    vecs.push_back(mk(256, 100, 40, 0,  0, 4'b0001));
    vecs.push_back(mk(311, 447, 40, 0,  0, 4'b0001));

    do_reset();

    foreach (vecs[i]) begin
      goto_pix(0, vecs[i].vc, vecs[i].hc);
      check($sformatf("vec%0d_%0d_%0d", i, vecs[i].vc, vecs[i].hc),
            {10'h0, R, G, B, HSync, VSync, line_start, int_n},
            {10'h0, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].flags});
      if (vecs[i].chk_addr)
        check($sformatf("addr%0d_%0d_%0d", i, vecs[i].vc, vecs[i].hc),
              {18'h0, vram_addr}, {18'h0, vecs[i].addr});
    end

    // Frame lengths measured between VSync rising edges.
    frame_len(n, low);
    check("first_vsync_found", (n < 200000) ? 32'd1 : 32'd0, 32'd1);
    frame_len(n, low);
    check("frame48_len", n, 32'd139776);
    check("int_low_count", low, 32'd64);
    mode_128 = 1'b1;
    frame_len(n, low);
    check("frame_mode_switch_len", n, 32'd141760);
    frame_len(n, low);
    check("frame128_len", n, 32'd141816);

    // Flash: ink while the frame counter is below 16, paper from frame 16.
    bitmap_val = 8'hFF; attr_val = 8'h87;
    goto_pix(15, 0, 8);
    check("flash_f15_ink", {14'h0, R, G, B}, {14'h0, 6'd40, 6'd40, 6'd40});
    repeat (7) @(negedge clk_sys);
    check("hold_no_ce", {14'h0, R, G, B}, {14'h0, 6'd40, 6'd40, 6'd40});
    goto_pix(15, 0, 300);
    check("f15_border", {14'h0, R, G, B}, {14'h0, 6'd40, 6'd0, 6'd0});
    goto_pix(16, 0, 8);
    check("flash_f16_paper", {14'h0, R, G, B}, 32'h0);
    goto_pix(16, 0, 300);
    check("f16_border", {14'h0, R, G, B}, {14'h0, 6'd40, 6'd0, 6'd0});
    goto_pix(16, 0, 330);
    check("f16_hblank", {13'h0, R, G, B, line_start}, 32'h1);
    goto_pix(16, 5, 100);
    check("flash_f16_paper_l5", {14'h0, R, G, B}, 32'h0);

    // Mid-frame reset restarts the frame and clears the flash counter.
    goto_pix(16, 100, 50);
    do_reset();
    goto_pix(0, 0, 8);
    check("post_reset_ink", {14'h0, R, G, B}, {14'h0, 6'd40, 6'd40, 6'd40});

    // Palette write with attr 00 / bitmap 00: paper pixels use palette entry 8.
    @(negedge clk_sys); pal_we = 1'b1; pal_addr = 6'd8; pal_data = 8'hE0;
    @(negedge clk_sys); pal_we = 1'b0;
    pal_enable = 1'b1; bitmap_val = 8'h00; attr_val = 8'h00;
    goto_pix(0, 2, 16);
`ifdef ULAPLUS_EN
    check("ulaplus_paper", {14'h0, R, G, B}, {14'h0, 6'd0, 6'd63, 6'd0});
`else
    check("pal_ignored_paper", {14'h0, R, G, B}, 32'h0);
    goto_pix(0, 2, 300);
    check("pal_ignored_border", {14'h0, R, G, B}, {14'h0, 6'd40, 6'd0, 6'd0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
